fp16_result_packer: RTL and testbench

- Downstream stage of the fp16 multiplier wrapper; consumes its result/valid stream.
- Packs LANES consecutive fp16 results into one wide word for the DMA write-back path, buffered in a small FIFO.
- The multiplier cannot be back-pressured, so the block raises an early stall request that upstream uses to gate the multiplier's valid_in.

---
 rtl/fp16_pkg.sv | 13 +
 rtl/sync_fifo_fwft.sv | 59 +++++
 rtl/fp16_result_packer.sv | 122 ++++++++++++
 tb/tb_fp16_result_packer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the multiplier result path.
// Holds the lane width, the zero pattern and the lane bit-slicing helper.
package fp16_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  // Bit offset of a given lane inside a packed multi-lane word.
  function automatic int lane_lsb(input int lane);
    return lane * FP16_W;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on o_rdata
// whenever o_empty is low. A push while full is accepted only alongside a pop.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_rd = i_pop & ~o_empty;
  // When full, the slot being written is the one being read out this cycle.
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fp16_result_packer.sv
// Packs LANES consecutive fp16 multiplier results into one wide word and queues
// it for DMA write-back; raises an early stall since the multiplier cannot wait.
module fp16_result_packer
  import fp16_pkg::*;
#(
  parameter int LANES        = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [FP16_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    stall,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FP16_W*LANES-1:0] out_data,
  output logic [LANES-1:0]        out_keep,
  output logic                    out_last,
  output logic                    overflow_err,
  input  logic                    clr_err
);

  localparam int DW  = FP16_W * LANES;
  localparam int FW  = DW + LANES + 1;
  localparam int LCW = $clog2(LANES);
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [LCW-1:0]   r_lane_cnt;
  logic [DW-1:0]    r_pack_data;
  logic [LANES-1:0] r_pack_keep;
  logic             r_stall;
  logic             r_overflow;

  logic [DW-1:0]    w_word_data;
  logic [LANES-1:0] w_word_keep;
  logic             w_complete;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [AW:0]      w_count_next;
  logic [FW-1:0]    w_fifo_wdata;
  logic [FW-1:0]    w_fifo_rdata;

  // The completing sample is merged combinationally so the word is pushed
  // in the same cycle as its final lane, keeping word boundaries bubble-free.
  always_comb begin
    w_word_data = r_pack_data;
    w_word_keep = r_pack_keep;
    if (in_valid) begin
      w_word_data[lane_lsb(int'(r_lane_cnt)) +: FP16_W] = in_data;
      w_word_keep[r_lane_cnt] = 1'b1;
    end
  end

  assign w_complete   = in_valid & ((r_lane_cnt == LCW'(LANES - 1)) | in_last);
  assign w_pop        = ~w_empty & out_ready;
  assign w_push_ok    = w_complete & (~w_full | w_pop);
  assign w_drop       = w_complete & ~w_push_ok;
  assign w_count_next = w_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
  assign w_fifo_wdata = {w_word_data, w_word_keep, in_last};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane_cnt  <= '0;
      r_pack_data <= '0;
      r_pack_keep <= '0;
    end else if (in_valid) begin
      if (w_complete) begin
        r_lane_cnt  <= '0;
        r_pack_data <= '0;
        r_pack_keep <= '0;
      end else begin
        r_lane_cnt  <= r_lane_cnt + LCW'(1);
        r_pack_data <= w_word_data;
        r_pack_keep <= w_word_keep;
      end
    end
  end

  // A dropped word beats a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_stall <= (FIFO_DEPTH - int'(w_count_next)) <= STALL_MARGIN;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push_ok),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign stall        = r_stall;
  assign overflow_err = r_overflow;
  assign out_valid    = ~w_empty;
  assign out_data     = w_empty ? {LANES{FP16_ZERO}} : w_fifo_rdata[FW-1 -: DW];
  assign out_keep     = w_empty ? '0 : w_fifo_rdata[LANES:1];
  assign out_last     = ~w_empty & w_fifo_rdata[0];

endmodule

// File: tb/tb_fp16_result_packer.sv
// Self-checking bench for fp16_result_packer: directed scenarios, a vector table
// and a randomized stream, all scored against a queue-based reference model.
module tb_fp16_result_packer;

  localparam int LANES  = 8;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   k;
    logic         l;
  } word_t;

  typedef struct {
    int          n;
    logic        last;
    logic [7:0]  exp_keep;
    logic        exp_last;
    logic [15:0] exp_lane7;
  } vec_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid, in_last, out_ready, clr_err;
  logic [15:0]  in_data;
  logic         stall, out_valid, out_last, overflow_err;
  logic [127:0] out_data;
  logic [7:0]   out_keep;

  word_t       q[$];
  logic [15:0] cur[$];
  logic        exp_stall, exp_ov;
  int          checks = 0;
  int          errors = 0;

  logic         cap_valid, cap_stall, cap_last, cap_ov;
  logic [127:0] cap_data;
  logic [7:0]   cap_keep;

  fp16_result_packer #(
    .LANES        (LANES),
    .FIFO_DEPTH   (DEPTH),
    .STALL_MARGIN (MARGIN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .stall        (stall),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .overflow_err (overflow_err),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic rdy, input logic clr);
    logic  pop, full_before, complete;
    word_t w;
    in_valid = v; in_data = d; in_last = l; out_ready = rdy; clr_err = clr;
    @(negedge clk);
    cap_valid = out_valid; cap_data = out_data; cap_keep = out_keep;
    cap_last = out_last; cap_stall = stall; cap_ov = overflow_err;
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_keep", out_keep, q[0].k);
      chk("out_last", out_last, q[0].l);
    end
    chk("stall", stall, exp_stall);
    chk("overflow_err", overflow_err, exp_ov);
    pop = (q.size() > 0) && rdy;
    full_before = (q.size() == DEPTH);
    complete = 1'b0;
    w.d = '0; w.k = '0; w.l = l;
    if (v) begin
      cur.push_back(d);
      if (cur.size() == LANES || l) begin
        for (int i = 0; i < cur.size(); i++) begin
          w.d[16*i +: 16] = cur[i];
          w.k[i] = 1'b1;
        end
        cur.delete();
        complete = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (complete && (!full_before || pop)) q.push_back(w);
    if (complete && full_before && !pop) exp_ov = 1'b1;
    else if (clr) exp_ov = 1'b0;
    exp_stall = (DEPTH - q.size()) <= MARGIN;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0; clr_err = 0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    q.delete(); cur.delete();
    exp_stall = 1'b0; exp_ov = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_out_keep", out_keep, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_overflow", overflow_err, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'h0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    vec_t        tbl[5];
    int          nwords, nstall, npops;
    logic        stall_hist[24];
    logic [127:0] held;
    logic [15:0] base;

    tbl[0] = '{1, 1'b1, 8'h01, 1'b1, 16'h0000};
    tbl[1] = '{5, 1'b1, 8'h1F, 1'b1, 16'h0000};
    tbl[2] = '{8, 1'b1, 8'hFF, 1'b1, 16'hA007};
    tbl[3] = '{8, 1'b0, 8'hFF, 1'b0, 16'hA007};
    tbl[4] = '{3, 1'b1, 8'h07, 1'b1, 16'h0000};

    // Reset in the middle of a word discards the partial word.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1111 * (i + 1), 1'b0, 1'b1, 1'b0);
    #3;
    do_reset();
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h3C00 + 16'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("midreset_valid", cap_valid, 1'b1);
    chk("midreset_lane0", cap_data[15:0], 16'h3C00);
    chk("midreset_lane7", cap_data[127:112], 16'h3C07);
    chk("midreset_keep", cap_keep, 8'hFF);
    chk("midreset_last", cap_last, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Full-rate stream: a word every 8 cycles, no stall.
    do_reset();
    nwords = 0; nstall = 0;
    for (int i = 0; i < 33; i++) begin
      if (i < 32) step(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0);
      else idle(1'b1);
      if (cap_valid) nwords++;
      if (cap_stall) nstall++;
      if (i == 8 || i == 16 || i == 24 || i == 32) chk("fullrate_latency", cap_valid, 1'b1);
    end
    chk("fullrate_words", nwords, 4);
    chk("fullrate_stall", nstall, 0);

    // Table of word-closing cases.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++)
        step(1'b1, 16'hA000 + 16'(i), (i == tbl[t].n - 1) ? tbl[t].last : 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      chk("tbl_valid", cap_valid, 1'b1);
      chk("tbl_keep", cap_keep, tbl[t].exp_keep);
      chk("tbl_last", cap_last, tbl[t].exp_last);
      chk("tbl_lane7", cap_data[127:112], tbl[t].exp_lane7);
      idle(1'b1);
      chk("tbl_single_word", cap_valid, 1'b0);
    end

    // Backpressure: stall one cycle after the second word lands, data held.
    do_reset();
    held = '0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
      stall_hist[i] = cap_stall;
      if (i == 8) held = cap_data;
    end
    chk("bp_stall_before", stall_hist[15], 1'b0);
    chk("bp_stall_after", stall_hist[16], 1'b1);
    idle(1'b0);
    chk("bp_hold", cap_data, held);
    chk("bp_no_overflow", cap_ov, 1'b0);
    npops = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      if (cap_valid) npops++;
    end
    chk("bp_drained", npops, 3);

    // Overflow, clear, and overflow coincident with clear.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("ovf_set", cap_ov, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("ovf_cleared", cap_ov, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0, i == 7);
    idle(1'b0);
    chk("ovf_beats_clr", cap_ov, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Word completes while full with a pop in the same cycle.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0, i == 39, 1'b0);
    idle(1'b0);
    chk("pushpop_no_ovf", cap_ov, 1'b0);
    npops = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (cap_valid) npops++;
    end
    chk("pushpop_count", npops, 4);

    // Randomized stream with phases of heavy and light backpressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      base = ((i / 400) % 2 == 0) ? 16'd3 : 16'd1;
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) < base, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
